// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared states and instruction-field codes for the instruction sequencer
//
// Holds the sequencer state enum, the opcodes that the sequencer itself
// decodes (HALT, NOP), and the branch / stack codes produced by the control unit.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    localparam logic [5:0] OP_HALT   = 6'd31;
    localparam logic [5:0] OP_NOP    = 6'd32;

    localparam logic [2:0] BR_ALWAYS = 3'd1;
    localparam logic [2:0] BR_MI     = 3'd2;
    localparam logic [2:0] BR_PL     = 3'd3;
    localparam logic [2:0] BR_Z      = 3'd4;

    localparam logic [2:0] ST_CALL   = 3'd3;
    localparam logic [2:0] ST_RET    = 3'd4;

endpackage

// File: rtl/branch_eval.sv
// rtl/branch_eval.sv - combinational branch condition evaluation
//
// Ports:
//   i_br        control-unit branch code
//   i_cond_val  value of the register tested by the branch
//   o_is_branch code names a real branch (1..4)
//   o_taken     branch condition holds
module branch_eval
    import seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_br,
    input  logic [DATA_W-1:0] i_cond_val,
    output logic              o_is_branch,
    output logic              o_taken
);

    always_comb begin
        o_is_branch = 1'b1;
        o_taken     = 1'b0;
        case (i_br)
            BR_ALWAYS: o_taken = 1'b1;
            BR_MI:     o_taken = i_cond_val[DATA_W-1];
            BR_PL:     o_taken = ~i_cond_val[DATA_W-1];
            BR_Z:      o_taken = (i_cond_val == '0);
            default:   o_is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer owning PC and IR
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              leave IDLE/HALT and fetch at the current pc
//   imem_*             instruction-memory fetch interface (read data valid the cycle after imem_on)
//   ir                 latched instruction for the control unit
//   cu_*, cond_val     registered control-unit decode of ir, branch test value
//   dmem_req/dmem_wr   data-memory request held until mem_ready
//   mem_rdata_pc       RET target from memory, link_pc = pc+1 stored by CALL
//   alu_en, reg_we     one-cycle ALU capture and register write strobes
//   halted, state_o    status
// Optional: SEQ_SINGLE_STEP_EN adds step_mode/step; with step_mode=1 each
// instruction ends in IDLE and a step pulse advances one instruction.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W     = 7,
    parameter int              DATA_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_on,
    output logic              imem_wr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] ir,
    input  logic [2:0]        cu_br,
    input  logic [2:0]        cu_st,
    input  logic              cu_memen,
    input  logic              cu_memwr,
    input  logic [1:0]        cu_wrreg,
    input  logic [DATA_W-1:0] cond_val,
    output logic              dmem_req,
    output logic              dmem_wr,
    input  logic              mem_ready,
    input  logic [PC_W-1:0]   mem_rdata_pc,
    output logic [PC_W-1:0]   link_pc,
    output logic              alu_en,
    output logic              reg_we,
    output logic              halted,
    output logic [2:0]        state_o
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic              step_mode,
    input  logic              step
`endif
);

    seq_state_t        r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [DATA_W-1:0] r_ir, w_ir_nxt;
    logic              w_is_branch, w_taken, w_run_req;
    logic [5:0]        w_dec_op;
    logic [PC_W-1:0]   w_pc_inc, w_pc_rel;

    assign w_dec_op = imem_data[31:26];
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_rel = r_pc + r_ir[PC_W-1:0];

`ifdef SEQ_SINGLE_STEP_EN
    assign w_run_req = step_mode ? step : start;
`else
    assign w_run_req = start;
`endif

    branch_eval #(.DATA_W(DATA_W)) u_branch_eval (
        .i_br        (cu_br),
        .i_cond_val  (cond_val),
        .o_is_branch (w_is_branch),
        .o_taken     (w_taken)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        imem_on     = 1'b0;
        dmem_req    = 1'b0;
        dmem_wr     = 1'b0;
        alu_en      = 1'b0;
        reg_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_run_req) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_on     = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // HALT/NOP are resolved from the memory word directly, since
                // the control unit only sees the instruction after ir updates.
                w_ir_nxt = imem_data;
                if (w_dec_op == OP_HALT) begin
                    w_state_nxt = S_HALT;
                end else if (w_dec_op == OP_NOP) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (w_is_branch) begin
                    w_pc_nxt    = w_taken ? w_pc_rel : w_pc_inc;
                    w_state_nxt = S_FETCH;
                end else if (cu_memen || cu_st == ST_CALL || cu_st == ST_RET) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                // CALL always stores the link address, whatever cu_memwr says.
                dmem_wr  = cu_memwr | (cu_st == ST_CALL);
                if (mem_ready) begin
                    if (cu_st == ST_CALL) begin
                        w_pc_nxt    = w_pc_rel;
                        w_state_nxt = S_FETCH;
                    end else if (cu_st == ST_RET) begin
                        w_pc_nxt    = mem_rdata_pc;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we      = (cu_wrreg != 2'd0);
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (w_run_req) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef SEQ_SINGLE_STEP_EN
        // Instruction completion parks in IDLE; leaving IDLE/HALT stays a fetch.
        if (step_mode && w_state_nxt == S_FETCH &&
            r_state != S_IDLE && r_state != S_HALT)
            w_state_nxt = S_IDLE;
`endif
    end

    assign imem_addr = r_pc;
    assign imem_wr   = 1'b0;
    assign ir        = r_ir;
    assign link_pc   = w_pc_inc;
    assign halted    = (r_state == S_HALT);
    assign state_o   = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench with an instruction-level reference model
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rstn, start;
    logic [6:0]  imem_addr, mem_rdata_pc, link_pc;
    logic        imem_on, imem_wr;
    logic [31:0] imem_data, ir, cond_val;
    logic [2:0]  cu_br, cu_st, state_o;
    logic        cu_memen, cu_memwr;
    logic [1:0]  cu_wrreg;
    logic        dmem_req, dmem_wr, mem_ready;
    logic        alu_en, reg_we, halted;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step_mode = 1'b0;
    logic        step      = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start),
        .imem_addr(imem_addr), .imem_on(imem_on), .imem_wr(imem_wr), .imem_data(imem_data),
        .ir(ir), .cu_br(cu_br), .cu_st(cu_st), .cu_memen(cu_memen), .cu_memwr(cu_memwr),
        .cu_wrreg(cu_wrreg), .cond_val(cond_val), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
        .mem_ready(mem_ready), .mem_rdata_pc(mem_rdata_pc), .link_pc(link_pc),
        .alu_en(alu_en), .reg_we(reg_we), .halted(halted), .state_o(state_o)
`ifdef SEQ_SINGLE_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    // Bench control unit. Opcode map: 0 ADD(wr), 1 ALU(no wr), 2..5 br 1..4,
    // 6 LD(wr), 7 ST, 8 CALL, 9 RET, 10 br code 6 with write, 31 HALT, 32 NOP.
    always_comb begin
        cu_br = 3'd0; cu_st = 3'd0; cu_memen = 1'b0; cu_memwr = 1'b0; cu_wrreg = 2'd0;
        case (ir[31:26])
            6'd0:  cu_wrreg = 2'd1;
            6'd2:  cu_br = 3'd1;
            6'd3:  cu_br = 3'd2;
            6'd4:  cu_br = 3'd3;
            6'd5:  cu_br = 3'd4;
            6'd6:  begin cu_memen = 1'b1; cu_wrreg = 2'd3; end
            6'd7:  begin cu_memen = 1'b1; cu_memwr = 1'b1; end
            6'd8:  cu_st = 3'd3;
            6'd9:  cu_st = 3'd4;
            6'd10: begin cu_br = 3'd6; cu_wrreg = 2'd2; end
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] ins;
        logic [31:0] cond;
        int          w;
        logic [6:0]  rd;
    } dir_t;

    typedef struct {
        logic [6:0] npc;
        int         lat;
        int         we;
        int         alu;
        int         dreq;
        int         dwr;
        bit         halt;
    } exp_t;

    dir_t dq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic dir_t mk(input logic [5:0] op, input logic [6:0] imm,
                                input logic [31:0] cond, input int w, input logic [6:0] rd);
        dir_t d;
        d.ins = {op, 19'd0, imm}; d.cond = cond; d.w = w; d.rd = rd;
        return d;
    endfunction

    function automatic dir_t rand_dir();
        dir_t d;
        int k;
        logic [5:0] op;
        k = $urandom_range(0, 13);
        if (k <= 10)      op = 6'(k);
        else if (k == 11) op = 6'd32;
        else if (k == 12) op = 6'd0;
        else              op = 6'd31;
        d.ins = {op, 26'($urandom)};
        case ($urandom_range(0, 2))
            0:       d.cond = 32'd0;
            1:       d.cond = $urandom & 32'h7fff_ffff;
            default: d.cond = $urandom | 32'h8000_0000;
        endcase
        d.w  = $urandom_range(0, 3);
        d.rd = 7'($urandom);
        return d;
    endfunction

    // Instruction-level outcome: next pc, cycles until the next fetch and strobe counts.
    function automatic exp_t predict(input logic [6:0] pc, input dir_t d);
        exp_t e;
        logic [5:0] op;
        logic [6:0] imm;
        bit tk;
        op = d.ins[31:26]; imm = d.ins[6:0];
        e.npc = pc + 7'd1; e.lat = 4; e.we = 0; e.alu = 1; e.dreq = 0; e.dwr = 0; e.halt = 0;
        tk = 0;
        case (op)
            6'd31: begin e.halt = 1; e.npc = pc; e.alu = 0; e.lat = 0; end
            6'd32: begin e.alu = 0; e.lat = 2; end
            6'd0, 6'd10: e.we = 1;
            6'd2, 6'd3, 6'd4, 6'd5: begin
                if (op == 6'd2)      tk = 1;
                else if (op == 6'd3) tk = ($signed(d.cond) < 0);
                else if (op == 6'd4) tk = ($signed(d.cond) >= 0);
                else                 tk = (d.cond == 32'd0);
                e.lat = 3;
                if (tk) e.npc = pc + imm;
            end
            6'd6: begin e.lat = 5 + d.w; e.dreq = d.w + 1; e.we = 1; end
            6'd7: begin e.lat = 5 + d.w; e.dreq = d.w + 1; e.dwr = d.w + 1; end
            6'd8: begin e.lat = 4 + d.w; e.dreq = d.w + 1; e.dwr = d.w + 1; e.npc = pc + imm; end
            6'd9: begin e.lat = 4 + d.w; e.dreq = d.w + 1; e.npc = d.rd; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_prog(input int n_instr, input bit reset_test);
        bit in_flight = 0;
        bit done = 0;
        int cyc = 0, mcnt = 0, hold = 0, issued = 0;
        int c_we = 0, c_alu = 0, c_dreq = 0, c_dwr = 0;
        logic [6:0] mpc = 7'd0;
        logic [6:0] pc_cur = 7'd0;
        exp_t e;
        dir_t d;
        e.halt = 0;
        d = mk(6'd1, 7'd0, 32'd0, 0, 7'd0);
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            cyc++;
            if (imem_on) begin
                if (in_flight) begin
                    chk("latency", cyc, e.lat);
                    chk("reg_we_count", c_we, e.we);
                    chk("alu_en_count", c_alu, e.alu);
                    chk("dmem_req_count", c_dreq, e.dreq);
                    chk("dmem_wr_count", c_dwr, e.dwr);
                end
                chk("fetch_addr", imem_addr, mpc);
                chk("imem_wr", imem_wr, 0);
                if (issued == n_instr) begin
                    done = 1;
                end else begin
                    if (reset_test && issued == n_instr - 1)
                        d = mk(6'd6, 7'd0, 32'd0, 6, 7'd0);
                    else if (dq.size() > 0)
                        d = dq.pop_front();
                    else
                        d = rand_dir();
                    imem_data    = d.ins;
                    cond_val     = d.cond;
                    mem_rdata_pc = d.rd;
                    e = predict(mpc, d);
                    if (e.halt) begin
                        hold  = $urandom_range(3, 6);
                        e.lat = hold + 1;
                    end
                    pc_cur = mpc;
                    mpc = e.npc;
                    cyc = 0; mcnt = 0; c_we = 0; c_alu = 0; c_dreq = 0; c_dwr = 0;
                    in_flight = 1;
                    issued++;
                end
            end else if (in_flight) begin
                c_we   += int'(reg_we);
                c_alu  += int'(alu_en);
                c_dreq += int'(dmem_req);
                c_dwr  += int'(dmem_req & dmem_wr);
                if (cyc > 20) begin
                    chk("fetch_timeout", cyc, e.lat);
                    done = 1;
                end
            end
            if (done) begin
                start = 1'b0;
            end else if (dmem_req) begin
                if (mcnt == 0) chk("link_pc", link_pc, 7'(pc_cur + 7'd1));
                if (reset_test && issued == n_instr && mcnt == 2) begin
                    rstn = 1'b0;
                    #1;
                    chk("rst_dmem_req", dmem_req, 0);
                    chk("rst_dmem_wr", dmem_wr, 0);
                    chk("rst_state", state_o, 0);
                    chk("rst_pc", imem_addr, 0);
                    chk("rst_ir", ir, 0);
                    chk("rst_strobes", {imem_on, alu_en, reg_we, halted}, 0);
                    for (int i = 0; i < 2; i++) begin
                        @(negedge clk);
                        chk("rst_no_wb", reg_we, 0);
                    end
                    rstn = 1'b1;
                    done = 1;
                end else begin
                    mem_ready = (mcnt == d.w);
                    mcnt++;
                end
                start = ($urandom_range(0, 5) == 0);
            end else begin
                mem_ready = 1'($urandom);
                if (e.halt && in_flight) begin
                    if (cyc == 2) begin
                        chk("halted", halted, 1);
                        chk("halt_state", state_o, 6);
                    end
                    start = (cyc == hold);
                end else begin
                    start = ($urandom_range(0, 5) == 0);
                end
            end
        end
        if (!done) chk("run_budget", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; mem_ready = 1'b0;
        imem_data = 32'd0; cond_val = 32'd0; mem_rdata_pc = 7'd0;
        repeat (2) @(negedge clk);
        chk("reset_state", state_o, 0);
        chk("reset_pc", imem_addr, 0);
        chk("reset_ir", ir, 0);
        chk("reset_strobes", {imem_on, dmem_req, dmem_wr, alu_en, reg_we, halted}, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", state_o, 0);
        chk("idle_no_fetch", imem_on, 0);

        dq.push_back(mk(6'd5, 7'd2,   32'd0, 0, 7'd0));  // BZ taken at 0 -> 2
        dq.push_back(mk(6'd5, 7'd2,   32'd5, 0, 7'd0));  // BZ not taken at 2 -> 3
        dq.push_back(mk(6'd0, 7'd0,   32'd0, 0, 7'd0));  // ADD at 3 -> 4
        dq.push_back(mk(6'd7, 7'd0,   32'd0, 3, 7'd0));  // ST, 3 wait cycles
        dq.push_back(mk(6'd2, 7'd5,   32'd0, 0, 7'd0));  // 5 -> 10
        dq.push_back(mk(6'd8, 7'd20,  32'd0, 1, 7'd0));  // CALL at 10 -> 30
        dq.push_back(mk(6'd9, 7'd0,   32'd0, 2, 7'd11)); // RET -> 11
        dq.push_back(mk(6'd2, 7'd116, 32'd0, 0, 7'd0));  // 11 -> 127
        dq.push_back(mk(6'd0, 7'd0,   32'd0, 0, 7'd0));  // ADDI at 127 wraps to 0
        dq.push_back(mk(6'd31, 7'd0,  32'd0, 0, 7'd0));  // HALT at 0
        run_prog(10, 1'b0);

        do_reset();
        run_prog(150, 1'b0);

        do_reset();
        run_prog(25, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
